// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults for the push-button debounce bank.
//   DEF_NUM_CH : default channel count
//   DEF_CNT_W  : default stability counter width (window = 2^CNT_W ticks)
//   DEF_RPT_W  : default auto-repeat counter width (period = 2^RPT_W ticks)
//   MAX_CH     : largest supported channel count
package debounce_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 18;
    localparam int DEF_RPT_W  = 8;
    localparam int MAX_CH     = 16;

endpackage

// File: rtl/debounce_bank_if.sv
// debounce_bank_if: button-side and event-side signals of the debounce bank.
//   tick      : counter enable / prescale strobe
//   pb        : raw asynchronous active-high buttons
//   pb_level  : debounced levels
//   pb_down   : one-cycle press pulses
//   pb_up     : one-cycle release pulses
//   pb_repeat : one-cycle auto-repeat pulses (0 unless auto-repeat is built in)
//   pb_any    : OR of the debounced levels
// master drives tick/pb and observes the events; slave is the debounce bank.
interface debounce_bank_if
    import debounce_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH
);

    logic              tick;
    logic [NUM_CH-1:0] pb;
    logic [NUM_CH-1:0] pb_level;
    logic [NUM_CH-1:0] pb_down;
    logic [NUM_CH-1:0] pb_up;
    logic [NUM_CH-1:0] pb_repeat;
    logic              pb_any;

    modport master (
        output tick, pb,
        input  pb_level, pb_down, pb_up, pb_repeat, pb_any
    );

    modport slave (
        input  tick, pb,
        output pb_level, pb_down, pb_up, pb_repeat, pb_any
    );

endinterface

// File: rtl/debounce_chan.sv
// debounce_chan: one push-button channel.
//   clk, rst_n : clock and synchronous active-low reset
//   tick       : counter enable
//   pb         : raw asynchronous button
//   level      : debounced level (registered state)
//   level_next : value level takes at the next edge (for the bank's pb_any)
//   down, up   : one-cycle pulses registered with the state toggle
//   rpt        : one-cycle auto-repeat pulse while held
// Optional feature: DEBOUNCE_BANK_AUTO_REPEAT_EN adds the auto-repeat counter;
// without it rpt is constant 0.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int RPT_W = DEF_RPT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic pb,
    output logic level,
    output logic level_next,
    output logic down,
    output logic up,
    output logic rpt
);

    logic             sync_p0;
    logic             sync_p1;
    logic             state;
    logic [CNT_W-1:0] cnt;
    logic             idle;
    logic             commit;

    // A channel is idle while the synchronized input agrees with the state;
    // any agreeing cycle, ticked or not, restarts the stability window.
    assign idle       = (state == sync_p1);
    assign commit     = !idle && tick && (&cnt);
    assign level_next = commit ? ~state : state;
    assign level      = state;

    // Synchronizer -> stability counter -> state and edge pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            state   <= 1'b0;
            cnt     <= '0;
            down    <= 1'b0;
            up      <= 1'b0;
        end else begin
            sync_p0 <= pb;
            sync_p1 <= sync_p0;
            if (idle || commit) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= cnt + 1'b1;
            end
            state <= level_next;
            down  <= commit && !state;
            up    <= commit && state;
        end
    end

`ifdef DEBOUNCE_BANK_AUTO_REPEAT_EN
    logic [RPT_W-1:0] rcnt;
    logic             rpt_hit;

    // A commit in either direction clears the repeat count, so a release on
    // the same edge as a would-be repeat suppresses that repeat.
    assign rpt_hit = state && tick && (&rcnt) && !commit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rcnt <= '0;
            rpt  <= 1'b0;
        end else begin
            if (!state || commit) begin
                rcnt <= '0;
            end else if (tick) begin
                rcnt <= rcnt + 1'b1;
            end
            rpt <= rpt_hit;
        end
    end
`else
    // Constant 0 for every legal repeat width.
    assign rpt = (RPT_W < 1);
`endif

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: NUM_CH independent push-button debouncers.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : debounce_bank_if.slave (tick, pb in; pb_level, pb_down, pb_up,
//           pb_repeat, pb_any out)
// Each channel has a 2-FF synchronizer, a tick-gated stability counter that
// commits after 2^CNT_W consecutive disagreeing ticks, and registered
// level/press/release pulses. pb_any is registered from the channels'
// next-state levels so it changes on the same edge as pb_level.
// Optional feature: define DEBOUNCE_BANK_AUTO_REPEAT_EN for pb_repeat pulses
// every 2^RPT_W ticks while held; otherwise pb_repeat is constant 0.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int RPT_W  = DEF_RPT_W
) (
    input logic            clk,
    input logic            rst_n,
    debounce_bank_if.slave bus
);

    logic [NUM_CH-1:0] level_next;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        debounce_chan #(
            .CNT_W (CNT_W),
            .RPT_W (RPT_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick       (bus.tick),
            .pb         (bus.pb[i]),
            .level      (bus.pb_level[i]),
            .level_next (level_next[i]),
            .down       (bus.pb_down[i]),
            .up         (bus.pb_up[i]),
            .rpt        (bus.pb_repeat[i])
        );
    end

    // Aggregate level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.pb_any <= 1'b0;
        end else begin
            bus.pb_any <= |level_next;
        end
    end

endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;
    localparam int NCH   = 2;
    localparam int CW    = 3;
    localparam int RW    = 2;
    localparam int WIN   = 1 << CW;
    localparam int RPT_P = 1 << RW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    debounce_bank_if #(.NUM_CH(NCH)) bus();

    debounce_bank #(
        .NUM_CH (NCH),
        .CNT_W  (CW),
        .RPT_W  (RW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    // Model state: levels, disagreeing-tick run lengths, pending pulse outputs
    logic [NCH-1:0] m_level = '0;
    logic [NCH-1:0] m_s0    = '0;
    logic [NCH-1:0] m_s1    = '0;
    logic [NCH-1:0] m_down  = '0;
    logic [NCH-1:0] m_up    = '0;
    logic [NCH-1:0] m_rep   = '0;
    logic           m_any   = 1'b0;
    int             m_run [NCH];
`ifdef DEBOUNCE_BANK_AUTO_REPEAT_EN
    int             m_held [NCH];
`endif

    initial begin
        for (int c = 0; c < NCH; c++) begin
            m_run[c] = 0;
`ifdef DEBOUNCE_BANK_AUTO_REPEAT_EN
            m_held[c] = 0;
`endif
        end
    end

    initial forever begin : mdl
        logic [NCH-1:0] n_down, n_up, n_rep;
        logic           commit;
        @(posedge clk);
        cyc = cyc + 1;
        if (!rst_n) begin
            m_level = '0; m_s0 = '0; m_s1 = '0;
            m_down = '0; m_up = '0; m_rep = '0; m_any = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                m_run[c] = 0;
`ifdef DEBOUNCE_BANK_AUTO_REPEAT_EN
                m_held[c] = 0;
`endif
            end
        end else begin
            n_down = '0; n_up = '0; n_rep = '0;
            for (int c = 0; c < NCH; c++) begin
                commit = 1'b0;
                if (m_s1[c] == m_level[c]) begin
                    m_run[c] = 0;
                end else if (bus.tick) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == WIN) begin
                        commit = 1'b1;
                        m_run[c] = 0;
                    end
                end
`ifdef DEBOUNCE_BANK_AUTO_REPEAT_EN
                if (m_level[c] && bus.tick) begin
                    m_held[c] = m_held[c] + 1;
                    if ((m_held[c] % RPT_P) == 0 && !commit) n_rep[c] = 1'b1;
                end
`endif
                if (commit) begin
                    if (m_level[c]) n_up[c] = 1'b1;
                    else            n_down[c] = 1'b1;
                    m_level[c] = ~m_level[c];
                end
`ifdef DEBOUNCE_BANK_AUTO_REPEAT_EN
                if (!m_level[c] || commit) m_held[c] = 0;
`endif
            end
            m_s1   = m_s0;
            m_s0   = bus.pb;
            m_down = n_down;
            m_up   = n_up;
            m_rep  = n_rep;
            m_any  = |m_level;
        end
    end

    // Per-cycle comparison of every output against the model
    initial forever begin
        @(negedge clk);
        checks = checks + 1;
        if ({bus.pb_level, bus.pb_down, bus.pb_up, bus.pb_repeat, bus.pb_any} !==
            {m_level, m_down, m_up, m_rep, m_any}) begin
            errors = errors + 1;
            $display("FAIL cycle %0d outputs: level=%b down=%b up=%b rep=%b any=%b expected level=%b down=%b up=%b rep=%b any=%b",
                     cyc, bus.pb_level, bus.pb_down, bus.pb_up, bus.pb_repeat, bus.pb_any,
                     m_level, m_down, m_up, m_rep, m_any);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int ups, downs, reps, reps_after, rise_k;
        bit stayed;
        bus.tick = 1'b1;
        bus.pb   = '0;

        // Reset state
        cycles(3);
        check("reset_level", 32'(bus.pb_level), 0);
        check("reset_any", 32'(bus.pb_any), 0);
        check("reset_pulses", 32'({bus.pb_down, bus.pb_up, bus.pb_repeat}), 0);
        rst_n = 1'b1;
        cycles(1);

        // Clean press on channel 0: commit on the 10th edge
        bus.pb = 2'b01;
        cycles(9);
        check("press_before", 32'(bus.pb_level), 0);
        cycles(1);
        check("press_level", 32'(bus.pb_level), 1);
        check("press_down", 32'(bus.pb_down), 1);
        check("press_any", 32'(bus.pb_any), 1);
        cycles(1);
        check("press_down_end", 32'(bus.pb_down), 0);
        check("press_ch1_idle", 32'(bus.pb_level[1]), 0);

        // Release held channel for 12 cycles
        bus.pb = 2'b00;
        ups = 0; downs = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.pb_up[0]) ups++;
            if (bus.pb_down[0]) downs++;
            if (k == 10) check("release_up_at10", 32'(bus.pb_up[0]), 1);
        end
        check("release_ups", ups, 1);
        check("release_downs", downs, 0);
        check("release_level", 32'(bus.pb_level), 0);
        check("release_any", 32'(bus.pb_any), 0);

        // Glitch: high 5, low 1, high again -> window restarts
        bus.pb = 2'b01;
        cycles(5);
        bus.pb = 2'b00;
        cycles(1);
        bus.pb = 2'b01;
        cycles(9);
        check("glitch_before", 32'(bus.pb_level[0]), 0);
        cycles(1);
        check("glitch_level", 32'(bus.pb_level[0]), 1);
        check("glitch_down", 32'(bus.pb_down[0]), 1);
        bus.pb = 2'b00;
        cycles(12);

        // Prescaled tick every 4th cycle on channel 1: commit at edge 32
        rise_k = -1;
        bus.pb = 2'b10;
        for (int k = 0; k < 60; k++) begin
            bus.tick = ((k % 4) == 0);
            @(negedge clk);
            if (bus.pb_level[1] && rise_k < 0) rise_k = k;
        end
        check("tick_commit_edge", rise_k, 32);

        // tick held low: level must not move despite the released input
        bus.tick = 1'b0;
        bus.pb   = 2'b00;
        stayed   = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!bus.pb_level[1]) stayed = 1'b0;
        end
        check("tick_freeze", 32'(stayed), 1);
        bus.tick = 1'b1;
        cycles(12);
        check("tick_resume_release", 32'(bus.pb_level), 0);

        // Reset mid-count with button held
        bus.pb = 2'b01;
        cycles(7);
        rst_n = 1'b0;
        downs = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.pb_down[0]) downs++;
        end
        check("rst_mid_down", downs, 0);
        check("rst_mid_level", 32'(bus.pb_level), 0);
        rst_n = 1'b1;
        cycles(9);
        check("rst_rel_before", 32'(bus.pb_level[0]), 0);
        cycles(1);
        check("rst_rel_level", 32'(bus.pb_level[0]), 1);
        check("rst_rel_down", 32'(bus.pb_down[0]), 1);
        bus.pb = 2'b00;
        cycles(12);

        // Long hold: auto-repeat every 4 cycles after press (if built in)
        bus.pb = 2'b01;
        reps = 0; downs = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.pb_repeat[0]) reps++;
            if (bus.pb_down[0]) downs++;
        end
        check("hold_downs", downs, 1);
`ifdef DEBOUNCE_BANK_AUTO_REPEAT_EN
        check("hold_repeats", reps, 5);
`else
        check("hold_repeats", reps, 0);
`endif
        bus.pb = 2'b00;
        ups = 0; reps_after = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ups > 0 && bus.pb_repeat[0]) reps_after++;
            if (bus.pb_up[0]) ups++;
        end
        check("hold_release_ups", ups, 1);
        check("hold_repeats_after_up", reps_after, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
